// File: rtl/video_timing_gen_pkg.sv
// Shared timing defaults and the axis segment classifier for the raster timing generator.
// Holds the board's 256x240 timing set and a standard 640x480@60 set.
package video_timing_gen_pkg;

  localparam int unsigned DEF_H_DISPLAY = 256;
  localparam int unsigned DEF_H_FRONT   = 7;
  localparam int unsigned DEF_H_SYNC    = 23;
  localparam int unsigned DEF_H_BACK    = 23;
  localparam int unsigned DEF_V_DISPLAY = 240;
  localparam int unsigned DEF_V_FRONT   = 14;
  localparam int unsigned DEF_V_SYNC    = 4;
  localparam int unsigned DEF_V_BACK    = 4;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  typedef enum logic [1:0] {
    SEG_DISPLAY = 2'd0,
    SEG_FRONT   = 2'd1,
    SEG_SYNC    = 2'd2,
    SEG_BACK    = 2'd3
  } axis_seg_e;

  // Segments follow each other in the order display, front porch, sync, back porch.
  function automatic axis_seg_e seg_of(input int unsigned pos, input int unsigned display,
                                       input int unsigned front, input int unsigned sync);
    axis_seg_e seg;
    if (pos < display) begin
      seg = SEG_DISPLAY;
    end else if (pos < display + front) begin
      seg = SEG_FRONT;
    end else if (pos < display + front + sync) begin
      seg = SEG_SYNC;
    end else begin
      seg = SEG_BACK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: position counter with wrap, plus sync and blank flags registered so they
// describe the position presented in the same cycle. Next-cycle blank is exported for the parent.
module video_timing_gen_axis_counter
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned FRONT   = DEF_H_FRONT,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BACK    = DEF_H_BACK,
  parameter bit          POL     = 1'b1,
  parameter int unsigned W       = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step_i,
  output logic [W-1:0] pos_o,
  output logic         sync_o,
  output logic         blank_o,
  output logic         blank_nxt_o,
  output logic         wrap_o
);

  localparam int unsigned TOTAL = DISPLAY + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  if ((64'd1 << W) < 64'(TOTAL)) begin : g_bad_width
    $error("axis counter width %0d cannot hold total %0d", W, TOTAL);
  end

  logic [W-1:0] pos_q, pos_d;
  logic         sync_q, sync_d;
  logic         blank_q, blank_d;
  axis_seg_e    seg_s;

  assign wrap_o = step_i && (pos_q == LAST);

  // Next position and the flags that belong to it.
  always_comb begin
    pos_d   = pos_q;
    sync_d  = ~POL;
    blank_d = 1'b1;
    if (wrap_o) begin
      pos_d = '0;
    end else if (step_i) begin
      pos_d = pos_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      pos_d = pos_q;
    end
    seg_s = seg_of(32'(pos_d), DISPLAY, FRONT, SYNC);
    case (seg_s)
      SEG_DISPLAY: begin
        sync_d  = ~POL;
        blank_d = 1'b0;
      end
      SEG_SYNC: begin
        sync_d  = POL;
        blank_d = 1'b1;
      end
      default: begin
        sync_d  = ~POL;
        blank_d = 1'b1;
      end
    endcase
  end

  // Axis state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q   <= '0;
      sync_q  <= ~POL;
      blank_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign pos_o       = pos_q;
  assign sync_o      = sync_q;
  assign blank_o     = blank_q;
  assign blank_nxt_o = blank_d;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters, sync, blanking, line/frame strobes.
// Optional frame counter enabled by defining VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_DISPLAY  = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned HPOS_W     = 9,
  parameter int unsigned VPOS_W     = 9,
  parameter int unsigned FCNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              display_on,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic h_wrap_s, v_wrap_s, v_step_s;
  logic h_blank_nxt_s, v_blank_nxt_s;
  logic line_start_q, frame_start_q, display_on_q;

  assign v_step_s = ce && h_wrap_s;

  video_timing_gen_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(H_SYNC_POL), .W(HPOS_W)
  ) u_h_axis (
    .clk        (clk),
    .reset_n    (reset_n),
    .step_i     (ce),
    .pos_o      (hpos),
    .sync_o     (hsync),
    .blank_o    (hblank),
    .blank_nxt_o(h_blank_nxt_s),
    .wrap_o     (h_wrap_s)
  );

  video_timing_gen_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(V_SYNC_POL), .W(VPOS_W)
  ) u_v_axis (
    .clk        (clk),
    .reset_n    (reset_n),
    .step_i     (v_step_s),
    .pos_o      (vpos),
    .sync_o     (vsync),
    .blank_o    (vblank),
    .blank_nxt_o(v_blank_nxt_s),
    .wrap_o     (v_wrap_s)
  );

  // Strobes fire only on the ce edge that wraps, so they are one clk wide whatever the ce duty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      display_on_q  <= 1'b1;
    end else begin
      line_start_q  <= h_wrap_s;
      frame_start_q <= v_wrap_s;
      display_on_q  <= !h_blank_nxt_s && !v_blank_nxt_s;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign display_on  = display_on_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Frames completed; wraps silently.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap_s) begin
      frame_cnt_d = frame_cnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: three instances (defaults, inverted sync, tiny raster)
// checked every cycle against a position model derived from the count of ce edges since reset.
module tb_video_timing_gen;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit hb;
    bit vb;
    bit de;
    bit ls;
    bit fs;
    int fc;
  } exp_t;

  // Expected outputs after n ce edges since reset; stepped = the last clk edge had ce=1.
  function automatic exp_t model(input longint n, input bit stepped,
                                 input int hd, input int hf, input int hsw, input int hbp,
                                 input int vd, input int vf, input int vsw, input int vbp,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht = hd + hf + hsw + hbp;
    int vt = vd + vf + vsw + vbp;
    e.h  = int'(n % ht);
    e.v  = int'((n / ht) % vt);
    e.hs = (e.h >= hd + hf && e.h < hd + hf + hsw) ? hp : !hp;
    e.vs = (e.v >= vd + vf && e.v < vd + vf + vsw) ? vp : !vp;
    e.hb = e.h >= hd;
    e.vb = e.v >= vd;
    e.de = !e.hb && !e.vb;
    e.ls = stepped && n > 0 && e.h == 0;
    e.fs = e.ls && e.v == 0;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    e.fc = int'((n / (ht * vt)) % 4);
`else
    e.fc = 0;
`endif
    return e;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: default timing, FCNT_W=2
  logic       rst0_n = 1'b0, ce0 = 1'b0;
  logic [8:0] hpos0, vpos0;
  logic       hsync0, vsync0, hblank0, vblank0, de0, ls0, fs0;
  logic [1:0] fc0;
  longint     n0 = 0;
  bit         st0 = 1'b0;

  video_timing_gen #(.FCNT_W(2)) dut0 (
    .clk(clk), .reset_n(rst0_n), .ce(ce0), .hpos(hpos0), .vpos(vpos0),
    .hsync(hsync0), .vsync(vsync0), .hblank(hblank0), .vblank(vblank0),
    .display_on(de0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  // Instance 1: default timing, inverted sync polarity
  logic       rst1_n = 1'b0, ce1 = 1'b0;
  logic [8:0] hpos1, vpos1;
  logic       hsync1, vsync1, hblank1, vblank1, de1, ls1, fs1;
  logic [7:0] fc1;
  longint     n1 = 0;
  bit         st1 = 1'b0;

  video_timing_gen #(.H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)) dut1 (
    .clk(clk), .reset_n(rst1_n), .ce(ce1), .hpos(hpos1), .vpos(vpos1),
    .hsync(hsync1), .vsync(vsync1), .hblank(hblank1), .vblank(vblank1),
    .display_on(de1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  // Instance 2: tiny raster 12x9 so whole frames are cheap
  localparam int SH_D = 8, SH_F = 1, SH_S = 2, SH_B = 1;
  localparam int SV_D = 6, SV_F = 1, SV_S = 1, SV_B = 1;
  localparam int S_FRAME = (SH_D + SH_F + SH_S + SH_B) * (SV_D + SV_F + SV_S + SV_B);
  logic       rst2_n = 1'b0, ce2 = 1'b0;
  logic [3:0] hpos2, vpos2;
  logic       hsync2, vsync2, hblank2, vblank2, de2, ls2, fs2;
  logic [1:0] fc2;
  longint     n2 = 0;
  bit         st2 = 1'b0;

  video_timing_gen #(
    .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .HPOS_W(4), .VPOS_W(4), .FCNT_W(2)
  ) dut2 (
    .clk(clk), .reset_n(rst2_n), .ce(ce2), .hpos(hpos2), .vpos(vpos2),
    .hsync(hsync2), .vsync(vsync2), .hblank(hblank2), .vblank(vblank2),
    .display_on(de2), .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
  );

  logic [26:0] obs0;
  logic [18:0] obs2;
  assign obs0 = {hpos0, vpos0, hsync0, vsync0, hblank0, vblank0, de0, ls0, fs0, fc0};
  assign obs2 = {hpos2, vpos2, hsync2, vsync2, hblank2, vblank2, de2, ls2, fs2, fc2};

  exp_t e;
  logic [26:0] exp0;
  logic [18:0] exp2;

  task automatic tick(input bit c0, input bit c1, input bit c2);
    ce0 = c0; ce1 = c1; ce2 = c2;
    @(posedge clk);
    if (c0 && rst0_n) n0++;
    if (c1 && rst1_n) n1++;
    if (c2 && rst2_n) n2++;
    st0 = c0 && rst0_n;
    st1 = c1 && rst1_n;
    st2 = c2 && rst2_n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    e = model(n0, st0, 256, 7, 23, 23, 240, 14, 4, 4, 1'b1, 1'b1);
    exp0 = {9'(e.h), 9'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
    n_checks++;
    if (obs0 !== exp0) begin
      n_fail++;
      $display("FAIL reset_dut0: got %h expected %h", obs0, exp0);
    end
    n_checks++;
    if ({hpos1, vpos1, hsync1, vsync1, hblank1, vblank1, de1, ls1, fs1} !== {18'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_dut1_inverted: got %h/%h sync %b%b", hpos1, vpos1, hsync1, vsync1);
    end
    e = model(n2, st2, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1, 1'b1);
    exp2 = {4'(e.h), 4'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
    n_checks++;
    if (obs2 !== exp2) begin
      n_fail++;
      $display("FAIL reset_dut2: got %h expected %h", obs2, exp2);
    end
  endtask

  task automatic test_hcount();
    rst0_n = 1'b1;
    for (int i = 0; i < 2 * 309 + 10; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      e = model(n0, st0, 256, 7, 23, 23, 240, 14, 4, 4, 1'b1, 1'b1);
      exp0 = {9'(e.h), 9'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
      n_checks++;
      if (obs0 !== exp0) begin
        n_fail++;
        $display("FAIL hcount n=%0d: got %h expected %h", n0, obs0, exp0);
      end
    end
  endtask

  task automatic test_polarity();
    rst1_n = 1'b1;
    for (int i = 0; i < 320; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      e = model(n1, st1, 256, 7, 23, 23, 240, 14, 4, 4, 1'b0, 1'b0);
      n_checks++;
      if ({hpos1, vpos1, hsync1, vsync1, hblank1, vblank1, de1, ls1, fs1} !==
          {9'(e.h), 9'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs}) begin
        n_fail++;
        $display("FAIL polarity n=%0d: got h=%0d hs=%b vs=%b hb=%b expected h=%0d hs=%b vs=%b hb=%b",
                 n1, hpos1, hsync1, vsync1, hblank1, e.h, e.hs, e.vs, e.hb);
      end
    end
  endtask

  task automatic test_ce_half();
    for (int i = 0; i < 800; i++) begin
      tick(1'((i % 2) == 0), 1'b0, 1'b0);
      e = model(n0, st0, 256, 7, 23, 23, 240, 14, 4, 4, 1'b1, 1'b1);
      exp0 = {9'(e.h), 9'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
      n_checks++;
      if (obs0 !== exp0) begin
        n_fail++;
        $display("FAIL ce_half n=%0d: got %h expected %h", n0, obs0, exp0);
      end
    end
  endtask

  task automatic test_ce_random();
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(1, 0)), 1'b0, 1'b0);
      e = model(n0, st0, 256, 7, 23, 23, 240, 14, 4, 4, 1'b1, 1'b1);
      exp0 = {9'(e.h), 9'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
      n_checks++;
      if (obs0 !== exp0) begin
        n_fail++;
        $display("FAIL ce_random n=%0d: got %h expected %h", n0, obs0, exp0);
      end
    end
  endtask

  task automatic test_frames_small();
    rst2_n = 1'b1;
    for (int i = 0; i < 5 * S_FRAME + 5; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      e = model(n2, st2, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1, 1'b1);
      exp2 = {4'(e.h), 4'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
      n_checks++;
      if (obs2 !== exp2) begin
        n_fail++;
        $display("FAIL frames_small n=%0d: got %h expected %h", n2, obs2, exp2);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst0_n = 1'b0;
    n0 = 0;
    st0 = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    rst0_n = 1'b1;
    for (int i = 0; i < 50 * 309 + 100; i++) tick(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (hpos0 !== 9'd100 || vpos0 !== 9'd50) begin
      n_fail++;
      $display("FAIL reach_100_50: got h=%0d v=%0d expected h=100 v=50", hpos0, vpos0);
    end
    #2;
    rst0_n = 1'b0;
    n0 = 0;
    st0 = 1'b0;
    #1;
    e = model(n0, st0, 256, 7, 23, 23, 240, 14, 4, 4, 1'b1, 1'b1);
    exp0 = {9'(e.h), 9'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
    n_checks++;
    if (obs0 !== exp0) begin
      n_fail++;
      $display("FAIL async_reset_mid: got %h expected %h", obs0, exp0);
    end
    tick(1'b1, 1'b0, 1'b0);
    rst0_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      e = model(n0, st0, 256, 7, 23, 23, 240, 14, 4, 4, 1'b1, 1'b1);
      exp0 = {9'(e.h), 9'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
      n_checks++;
      if (obs0 !== exp0) begin
        n_fail++;
        $display("FAIL after_reset_mid n=%0d: got %h expected %h", n0, obs0, exp0);
      end
    end
  endtask

  task automatic test_frame_after_reset();
    int  edges;
    bit  found;
    for (int i = 0; i < 37; i++) tick(1'b0, 1'b0, 1'($urandom_range(1, 0)));
    #2;
    rst2_n = 1'b0;
    n2 = 0;
    st2 = 1'b0;
    #1;
    e = model(n2, st2, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B, 1'b1, 1'b1);
    exp2 = {4'(e.h), 4'(e.v), e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, 2'(e.fc)};
    n_checks++;
    if (obs2 !== exp2) begin
      n_fail++;
      $display("FAIL async_reset_small: got %h expected %h", obs2, exp2);
    end
    tick(1'b0, 1'b0, 1'b1);
    rst2_n = 1'b1;
    edges = 0;
    found = 1'b0;
    for (int i = 0; i < 3 * S_FRAME && !found; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      edges++;
      if (fs2 === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || edges != S_FRAME) begin
      n_fail++;
      $display("FAIL frame_after_reset: got found=%0d edges=%0d expected edges=%0d", found, edges, S_FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_hcount();
    test_polarity();
    test_ce_half();
    test_ce_random();
    test_frames_small();
    test_reset_mid();
    test_frame_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
